aes_stream_ingress: RTL and testbench

- Upstream feeder for the fully pipelined AES-128 core.
- Accepts a 32-bit valid/ready word stream and packs four words into one 128-bit block.
- Issues each block to the core as a single-cycle enable pulse with data.
- Owns the core's key and decrypt inputs. Because the core selects round keys combinationally from decrypt/key, this block guarantees both stay stable while any block is in flight, draining the pipeline before changing either.

---
 rtl/aes_stream_ingress.sv | 154 +++++++++++++++
 tb/tb_aes_stream_ingress.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ingress.sv
// aes_stream_ingress: packs a 32-bit valid/ready word stream into 128-bit
// blocks for a fully pipelined AES-128 core. It also owns the core's key and
// decrypt inputs, and changes them only once the core pipeline has drained.
//
// state  | meaning
// -------+------------------------------------------------------------------
// RUN    | accepting words; key/mode checked at each block boundary
// DRAIN  | not accepting; waiting for the core pipeline to empty
// SETTLE | new key applied; holding off while key expansion registers it
module aes_stream_ingress #(
  parameter int PIPE_DEPTH = 22,
  parameter int KEY_SETTLE = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_decrypt,
  input  logic [127:0]     key_in,
  input  logic             key_load,
  output logic             aes_enable,
  output logic [127:0]     aes_data_in,
  output logic [127:0]     aes_key,
  output logic             aes_decrypt,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_issued
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam int SW = (KEY_SETTLE < 1) ? 1 : $clog2(KEY_SETTLE + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      word_cnt;
  logic [95:0]     asm_q;
  logic [DW-1:0]   drain_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            key_valid;
  logic            key_pending;
  logic [127:0]    key_pend_q;
  logic            drain_exit;
  logic            boundary_hold;
  logic            hs;

  assign hs   = s_valid && s_ready;
  assign busy = (word_cnt != 2'd0) || (drain_cnt != '0) || (state != ST_RUN);

  // Next state, ready, and the drain-exit strobe; checks only at block boundaries
  always_comb begin
    state_nxt     = state;
    s_ready       = 1'b0;
    drain_exit    = 1'b0;
    boundary_hold = (word_cnt == 2'd0) &&
                    (key_pending || (s_valid && (s_decrypt != aes_decrypt)));
    case (state)
      ST_RUN: begin
        if (boundary_hold) state_nxt = ST_DRAIN;
        else               s_ready   = 1'b1;
      end
      ST_DRAIN: begin
        if ((drain_cnt == '0) && !aes_enable && (key_valid || key_pending)) begin
          drain_exit = 1'b1;
          if (key_pending && (KEY_SETTLE != 0)) state_nxt = ST_SETTLE;
          else                                  state_nxt = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt <= SW'(1)) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_DRAIN;
    endcase
  end

  // State register; reset parks in DRAIN until a key is available
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_DRAIN;
    else     state <= state_nxt;
  end

  // Word assembly and block issue; word 3 bypasses straight into the block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt      <= 2'd0;
      asm_q         <= '0;
      aes_data_in   <= '0;
      aes_enable    <= 1'b0;
      blocks_issued <= '0;
    end else begin
      aes_enable <= 1'b0;
      if (hs) begin
        word_cnt <= word_cnt + 2'd1;
        case (word_cnt)
          2'd0: asm_q[95:64] <= s_data;
          2'd1: asm_q[63:32] <= s_data;
          2'd2: asm_q[31:0]  <= s_data;
          default: begin
            aes_data_in   <= {asm_q, s_data};
            aes_enable    <= 1'b1;
            blocks_issued <= blocks_issued + CNT_W'(1);
          end
        endcase
      end
    end
  end

  // Drain timer: reloads on every issue pulse, counts down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    drain_cnt <= '0;
    else if (aes_enable)        drain_cnt <= DW'(PIPE_DEPTH);
    else if (drain_cnt != '0)   drain_cnt <= drain_cnt - DW'(1);
  end

  // Key settle timer, started when a new key is applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      settle_cnt <= '0;
    else if (drain_exit && key_pending)
      settle_cnt <= SW'(KEY_SETTLE);
    else if ((state == ST_SETTLE) && (settle_cnt != '0))
      settle_cnt <= settle_cnt - SW'(1);
  end

  // Key and mode registers; a key_load on the exit edge stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_key     <= '0;
      aes_decrypt <= 1'b0;
      key_valid   <= 1'b0;
      key_pending <= 1'b0;
      key_pend_q  <= '0;
    end else begin
      if (drain_exit) begin
        if (s_valid) aes_decrypt <= s_decrypt;
        if (key_pending) begin
          aes_key     <= key_pend_q;
          key_valid   <= 1'b1;
          key_pending <= 1'b0;
        end
      end
      if (key_load) begin
        key_pend_q  <= key_in;
        key_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_ingress.sv
// Bench for aes_stream_ingress: a block-level scoreboard plus directed tests.
module tb_aes_stream_ingress;

  localparam int PIPE_DEPTH = 22;
  localparam int KEY_SETTLE = 2;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] K3 = 128'hcafebabe0badf00ddeadbeef55aa55aa;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_decrypt;
  logic [127:0] key_in;
  logic         key_load;
  logic         aes_enable;
  logic [127:0] aes_data_in;
  logic [127:0] aes_key;
  logic         aes_decrypt;
  logic         busy;
  logic [31:0]  blocks_issued;

  logic         s_ready4, aes_enable4, aes_decrypt4, busy4;
  logic [127:0] aes_data_in4, aes_key4;
  logic [3:0]   blocks_issued4;

  aes_stream_ingress #(.PIPE_DEPTH(PIPE_DEPTH), .KEY_SETTLE(KEY_SETTLE), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_decrypt(s_decrypt), .key_in(key_in), .key_load(key_load),
    .aes_enable(aes_enable), .aes_data_in(aes_data_in), .aes_key(aes_key),
    .aes_decrypt(aes_decrypt), .busy(busy), .blocks_issued(blocks_issued)
  );

  aes_stream_ingress #(.PIPE_DEPTH(PIPE_DEPTH), .KEY_SETTLE(KEY_SETTLE), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
    .s_decrypt(s_decrypt), .key_in(key_in), .key_load(key_load),
    .aes_enable(aes_enable4), .aes_data_in(aes_data_in4), .aes_key(aes_key4),
    .aes_decrypt(aes_decrypt4), .busy(busy4), .blocks_issued(blocks_issued4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard state
  int           cyc = 0;
  int           nwords = 0;
  int           exp_cnt = 0;
  int           n_en = 0;
  int           hs_idx = 0;
  int           last_en_idx = 0;
  int           dec_chg_idx = 0;
  int           key_chg_idx = 0;
  int           key_chg_cnt = 0;
  int           since_en = 1000;
  int           en_q[$];
  bit           exp_en = 1'b0;
  bit           key_seen = 1'b0;
  bit           blk_dec = 1'b0;
  bit           prev_dec = 1'b0;
  logic [127:0] asmb = '0;
  logic [127:0] exp_data = '0;
  logic [127:0] latest_key = '0;
  logic [127:0] blk_key = '0;
  logic [127:0] prev_key = '0;
  logic [127:0] last_en_key = '0;

  // Compare process: outputs are checked on the falling edge, then the
  // handshake about to happen on the next rising edge updates the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_enable", aes_enable, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_count", blocks_issued, 0);
      chk("rst_count4", blocks_issued4, 0);
      chk("rst_key", aes_key, 0);
      chk("rst_data", aes_data_in, 0);
      chk("rst_decrypt", aes_decrypt, 0);
      nwords = 0; exp_en = 0; exp_cnt = 0; exp_data = '0;
      key_seen = 0; prev_key = '0; prev_dec = 0; since_en = 1000;
    end else begin
      chk("enable", aes_enable, exp_en);
      chk("enable4", aes_enable4, exp_en);
      chk("data", aes_data_in, exp_data);
      chk("data4", aes_data_in4, exp_data);
      chk("count", blocks_issued, exp_cnt);
      chk("count4", blocks_issued4, exp_cnt % 16);
      if (nwords != 0) begin
        chk("busy_partial", busy, 1);
        chk("busy4_partial", busy4, 1);
      end
      if (!key_seen) begin
        chk("ready_nokey", s_ready, 0);
        chk("ready4_nokey", s_ready4, 0);
      end
      if (aes_enable) begin
        chk("block_key", aes_key, blk_key);
        chk("block_mode", aes_decrypt, blk_dec);
      end
      if (aes_enable4) begin
        chk("block_key4", aes_key4, blk_key);
        chk("block_mode4", aes_decrypt4, blk_dec);
      end
      if (since_en < 1000) since_en++;
      if ((aes_key !== prev_key) || (aes_decrypt !== prev_dec)) begin
        chk("chg_after_drain", since_en > PIPE_DEPTH, 1);
        chk("chg_no_partial", nwords, 0);
        chk("chg_no_enable", aes_enable, 0);
        if (aes_key !== prev_key) begin key_chg_idx = cyc; key_chg_cnt++; end
        if (aes_decrypt !== prev_dec) dec_chg_idx = cyc;
      end
      prev_key = aes_key;
      prev_dec = aes_decrypt;
      if (aes_enable) begin
        since_en = 0; n_en++; last_en_idx = cyc; last_en_key = aes_key;
        en_q.push_back(cyc);
      end
      exp_en = 0;
      if (s_valid && s_ready) begin
        hs_idx = cyc;
        if (nwords == 0) begin blk_key = latest_key; blk_dec = s_decrypt; end
        asmb[127 - 32*nwords -: 32] = s_data;
        nwords++;
        if (nwords == 4) begin
          exp_data = asmb; exp_en = 1; exp_cnt++; nwords = 0;
        end
      end
      if (key_load) begin latest_key = key_in; key_seen = 1; end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit dec);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_decrypt = dec;
    @(negedge clk);
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (!s_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic stream(input int nblk, input bit dec, output int low);
    low = 0;
    for (int i = 0; i < nblk*4; i++) begin
      s_valid = 1'b1; s_data = 32'hA500_0000 + i; s_decrypt = dec;
      @(negedge clk);
      if (!s_ready) low++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_count_direct", blocks_issued, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, low, bad, kc0, en_ref, ready_hi;
    rst = 1'b1; s_valid = 0; s_data = '0; s_decrypt = 0; key_in = '0; key_load = 0;
    wait_cyc(2);
    do_reset();

    // No key yet: nothing may be accepted
    ready_hi = 0; n0 = n_en;
    s_valid = 1'b1; s_data = 32'h5555_5555;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); if (s_ready) ready_hi++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("nokey_ready_cycles", ready_hi, 0);
    chk("nokey_enables", n_en - n0, 0);

    // First key and first block
    load_key(K1);
    wait_cyc(PIPE_DEPTH + KEY_SETTLE + 2);
    chk("key1_applied", aes_key, K1);
    n0 = n_en;
    send_word(32'h00112233, 0);
    send_word(32'h44556677, 0);
    send_word(32'h8899aabb, 0);
    send_word(32'hccddeeff, 0);
    wait_cyc(2);
    chk("blk1_enables", n_en - n0, 1);
    chk("blk1_latency", last_en_idx - hs_idx, 1);
    chk("blk1_data", aes_data_in, 128'h00112233445566778899aabbccddeeff);
    chk("blk1_count", blocks_issued, 1);

    // Eight back-to-back blocks
    en_q.delete();
    stream(8, 0, low);
    wait_cyc(2);
    chk("stream_ready_low", low, 0);
    chk("stream_enables", en_q.size(), 8);
    bad = 0;
    for (int i = 1; i < en_q.size(); i++) if (en_q[i] - en_q[i-1] != 4) bad++;
    chk("stream_spacing", bad, 0);
    chk("stream_count", blocks_issued, 9);

    // Mode change waits for the drain
    send_word(32'h01010101, 0);
    send_word(32'h02020202, 0);
    send_word(32'h03030303, 0);
    send_word(32'h04040404, 0);
    en_ref = cyc + 1;
    send_word(32'h10101010, 1);
    chk("mode_en_ref", last_en_idx, en_ref);
    chk("mode_flip_delay", dec_chg_idx - last_en_idx, PIPE_DEPTH + 2);
    chk("mode_accept_delay", hs_idx - last_en_idx, PIPE_DEPTH + 2);
    chk("mode_now_decrypt", aes_decrypt, 1);
    send_word(32'h20202020, 1);
    send_word(32'h30303030, 1);
    send_word(32'h40404040, 1);
    wait_cyc(2);
    chk("mode_blk_data", aes_data_in, 128'h10101010202020203030303040404040);
    chk("mode_count", blocks_issued, 11);

    // Key load mid-block, second load during drain
    send_word(32'haaaa0000, 1);
    send_word(32'haaaa0001, 1);
    load_key(K2);
    send_word(32'haaaa0002, 1);
    send_word(32'haaaa0003, 1);
    wait_cyc(2);
    chk("midblk_old_key", last_en_key, K1);
    kc0 = key_chg_cnt;
    wait_cyc(3);
    load_key(K3);
    send_word(32'hbbbb0000, 1);
    chk("drain_key_changes", key_chg_cnt - kc0, 1);
    chk("drain_key_value", aes_key, K3);
    chk("settle_hold", hs_idx - key_chg_idx, KEY_SETTLE);
    send_word(32'hbbbb0001, 1);
    send_word(32'hbbbb0002, 1);
    send_word(32'hbbbb0003, 1);
    wait_cyc(2);
    chk("newkey_block_key", last_en_key, K3);
    chk("key_count", blocks_issued, 13);

    // Reset mid-block discards the partial block
    send_word(32'h77777777, 1);
    send_word(32'h88888888, 1);
    do_reset();
    load_key(K1);
    wait_cyc(PIPE_DEPTH + KEY_SETTLE + 2);
    n0 = n_en;
    send_word(32'hdeadbeef, 0);
    send_word(32'h01234567, 0);
    send_word(32'h89abcdef, 0);
    send_word(32'hfedcba98, 0);
    wait_cyc(2);
    chk("rst_blk_data", aes_data_in, 128'hdeadbeef0123456789abcdeffedcba98);
    chk("rst_blk_enables", n_en - n0, 1);
    chk("rst_blk_count", blocks_issued, 1);

    // Counter wrap on the narrow-counter instance
    stream(15, 0, low);
    wait_cyc(2);
    chk("wrap_ready_low", low, 0);
    chk("wrap_count32", blocks_issued, 16);
    chk("wrap_count4", blocks_issued4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
